// File: rtl/trace_capture_buf_pkg.sv
// Shared constants for the trace capture buffer: word width, header layout and FSM state codes.
package trace_capture_buf_pkg;

    localparam int DW          = 16;
    localparam int HDR_OVF_BIT = 15;
    localparam int HDR_CNT_MSB = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_PREP = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Header word: overflow flag in the top bit, sample count in the low bits, zeros between.
    function automatic logic [DW-1:0] make_header(input logic ovf, input logic [HDR_CNT_MSB:0] cnt);
        logic [DW-1:0] h;
        h                 = '0;
        h[HDR_OVF_BIT]    = ovf;
        h[HDR_CNT_MSB:0]  = cnt;
        return h;
    endfunction

endpackage

// File: rtl/trace_capture_buf_fifo.sv
// Synchronous 2^AW x DW sample FIFO with a registered read port; pop only advances the read pointer.
module trace_fifo #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk_ref,
    input  logic          rst_n_o,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pull;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;
    assign push      = wr_en_i && !full_o;
    assign pull      = pop_i && !empty_o;

    always_ff @(posedge clk_ref) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n_o) begin
        if (!rst_n_o) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pull) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pull) begin
                count_q <= count_q + 1'b1;
            end else if (pull && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_capture_buf.sv
// Trace capture buffer: stores DUT samples during a run and dumps them, header first,
// as paced single-cycle pulses toward the station return path.
module trace_capture_buf #(
    parameter int DW  = 16,
    parameter int AW  = 8,
    parameter int GAP = 4
) (
    input  logic          clk_ref,
    input  logic          rst_n_o,
    input  logic          run_verif_i,
    input  logic          capt_trce_i,
    input  logic [DW-1:0] dut_data_i,
    input  logic          ctrl_trace_i,
    input  logic          busy_i,
    output logic [DW-1:0] data_trace_o,
    output logic          dv_trace_o,
    output logic [AW:0]   fifo_count_o,
    output logic          overflow_o,
    output logic          dump_done_o
);
    import trace_capture_buf_pkg::*;

    localparam int            GW      = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP);
    localparam logic [AW:0]   ONE_CNT = (AW+1)'(1);

    state_t        state_q, state_d;
    logic          ctrl_q;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] hdr_q, hdr_d;
    logic [DW-1:0] data_q, data_d;
    logic          dv_q, dv_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          capture_try;
    logic          rise;
    logic          issue_ok;
    logic          issue;
    logic          rd_en;
    logic          pop;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    // The trace is frozen whenever a dump is in progress.
    assign capture_try = capt_trce_i && run_verif_i && (state_q == ST_IDLE);
    assign rise        = ctrl_trace_i && !ctrl_q;
    assign issue_ok    = !busy_i && (gap_q == '0);

    trace_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk_ref   (clk_ref),
        .rst_n_o   (rst_n_o),
        .wr_en_i   (capture_try),
        .wr_data_i (dut_data_i),
        .rd_en_i   (rd_en),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        rd_en   = 1'b0;
        pop     = 1'b0;
        issue   = 1'b0;

        if (capture_try && fifo_full) begin
            ovf_d = 1'b1;
        end

        // Dropping the select abandons the dump; unsent samples stay queued for the next one.
        if ((state_q != ST_IDLE) && !ctrl_trace_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        hdr_d   = make_header(ovf_q, fifo_count[HDR_CNT_MSB:0]);
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (issue_ok) begin
                        data_d  = hdr_q;
                        dv_d    = 1'b1;
                        issue   = 1'b1;
                        state_d = (hdr_q[HDR_CNT_MSB:0] == '0) ? ST_DONE : ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (fifo_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (issue_ok) begin
                        data_d  = fifo_rd_data;
                        dv_d    = 1'b1;
                        pop     = 1'b1;
                        issue   = 1'b1;
                        state_d = (fifo_count == ONE_CNT) ? ST_DONE : ST_PREP;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Gap runs down in every state so pacing survives an abort and restart.
        if (issue) begin
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else begin
            gap_d = '0;
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n_o) begin
        if (!rst_n_o) begin
            state_q <= ST_IDLE;
            ctrl_q  <= 1'b0;
            gap_q   <= '0;
            hdr_q   <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_trace_i;
            gap_q   <= gap_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_trace_o = data_q;
    assign dv_trace_o   = dv_q;
    assign fifo_count_o = fifo_count;
    assign overflow_o   = ovf_q;
    assign dump_done_o  = done_q;

endmodule
